// File: rtl/usb_tx_pkg.sv
// Shared types and line symbols for the USB transmit path.
package usb_tx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATA    = 2'd1,
    EOP_SE0 = 2'd2,
    EOP_J   = 2'd3
  } tx_state_t;

  // Line symbols as {dplus, dminus}
  localparam logic [1:0] J_FS = 2'b10;
  localparam logic [1:0] K_FS = 2'b01;
  localparam logic [1:0] J_LS = 2'b01;
  localparam logic [1:0] K_LS = 2'b10;
  localparam logic [1:0] SE0  = 2'b00;

  localparam int unsigned DEFAULT_STUFF_LIMIT = 6;

  // NRZI transition between the two idle-polarity symbols
  function automatic logic [1:0] nrzi_toggle(input logic [1:0] line,
                                             input logic [1:0] j_sym,
                                             input logic [1:0] k_sym);
    return (line == j_sym) ? k_sym : j_sym;
  endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// Bit-period timer: tick is high on the last system clock of each bit period.
module usb_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] remain_q;

  // Down-count of clocks remaining in the period; a full reload is the
  // equivalent of an up-counter sitting at zero, and wraps at each tick.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      remain_q <= RELOAD;
    end else if (restart || (remain_q == '0)) begin
      remain_q <= RELOAD;
    end else begin
      remain_q <= remain_q - CW'(1);
    end
  end

  assign tick = (remain_q == '0);

endmodule

// File: rtl/usb_nrzi_tx.sv
// USB transmit line encoder: paced NRZI encoding, bit stuffing and EOP generation.
module usb_nrzi_tx
  import usb_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned STUFF_LIMIT  = DEFAULT_STUFF_LIMIT,
  parameter int unsigned EOP_SE0_BITS = 2,
  parameter bit          LOW_SPEED    = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic bit_valid,
  input  logic bit_data,
  input  logic bit_last,
  output logic bit_ready,
  output logic dplus_out,
  output logic dminus_out,
  output logic busy,
  output logic eop_done,
  output logic underrun
);

  localparam int unsigned OW = $clog2(STUFF_LIMIT + 1);
  localparam int unsigned SW = $clog2(EOP_SE0_BITS + 1);
  localparam logic [1:0]    J_SYM    = LOW_SPEED ? J_LS : J_FS;
  localparam logic [1:0]    K_SYM    = LOW_SPEED ? K_LS : K_FS;
  localparam logic [OW-1:0] STUFF_AT = OW'(STUFF_LIMIT);
  localparam logic [SW-1:0] SE0_LAST = SW'(EOP_SE0_BITS - 1);

  tx_state_t     state_q, state_d;
  logic [1:0]    line_q, line_d;
  logic [OW-1:0] ones_q, ones_d;
  logic [SW-1:0] se0_q, se0_d;
  logic          last_q, last_d;
  logic          underrun_q, underrun_d;
  logic          eop_q, eop_d;
  logic          tick;
  logic          restart;
  logic          stuff_pending;

  usb_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .n_rst  (n_rst),
    .restart(restart),
    .tick   (tick)
  );

  assign stuff_pending = (ones_q == STUFF_AT);

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: transitions happen only at bit-period boundaries
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bit_valid) state_d = DATA;
      DATA:    if (tick && !stuff_pending && (last_q || !bit_valid)) state_d = EOP_SE0;
      EOP_SE0: if (tick && (se0_q == SE0_LAST)) state_d = EOP_J;
      EOP_J:   if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: consume in IDLE, or at a data tick with no stuff or EOP pending
  always_comb begin
    bit_ready = (state_q == IDLE) ||
                ((state_q == DATA) && tick && !stuff_pending && !last_q);
    busy      = (state_q != IDLE);
  end

  // Datapath next values: line symbol, stuffing count, last flag, SE0 periods, pulses
  always_comb begin
    line_d     = line_q;
    ones_d     = ones_q;
    last_d     = last_q;
    se0_d      = se0_q;
    underrun_d = 1'b0;
    eop_d      = 1'b0;
    restart    = 1'b0;
    case (state_q)
      IDLE: begin
        line_d = J_SYM;
        ones_d = '0;
        last_d = 1'b0;
        se0_d  = '0;
        if (bit_valid) begin
          // Zero-latency first bit: the line before it is always J
          line_d  = bit_data ? J_SYM : K_SYM;
          ones_d  = bit_data ? OW'(1) : '0;
          last_d  = bit_last;
          restart = 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          if (stuff_pending) begin
            line_d = nrzi_toggle(line_q, J_SYM, K_SYM);
            ones_d = '0;
          end else if (last_q) begin
            line_d = SE0;
            last_d = 1'b0;
            se0_d  = '0;
          end else if (bit_valid) begin
            line_d = bit_data ? line_q : nrzi_toggle(line_q, J_SYM, K_SYM);
            ones_d = bit_data ? (ones_q + OW'(1)) : '0;
            last_d = bit_last;
          end else begin
            underrun_d = 1'b1;
            line_d     = SE0;
            se0_d      = '0;
          end
        end
      end
      EOP_SE0: begin
        if (tick) begin
          if (se0_q == SE0_LAST) begin
            line_d = J_SYM;
            se0_d  = '0;
          end else begin
            se0_d = se0_q + SW'(1);
          end
        end
      end
      EOP_J: begin
        if (tick) begin
          eop_d  = 1'b1;
          ones_d = '0;
        end
      end
      default: begin
        line_d = J_SYM;
      end
    endcase
  end

  // Datapath registers; reset forces the line back to J immediately
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      line_q     <= J_SYM;
      ones_q     <= '0;
      last_q     <= 1'b0;
      se0_q      <= '0;
      underrun_q <= 1'b0;
      eop_q      <= 1'b0;
    end else begin
      line_q     <= line_d;
      ones_q     <= ones_d;
      last_q     <= last_d;
      se0_q      <= se0_d;
      underrun_q <= underrun_d;
      eop_q      <= eop_d;
    end
  end

  assign dplus_out  = line_q[1];
  assign dminus_out = line_q[0];
  assign eop_done   = eop_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_usb_nrzi_tx.sv
// Directed bench for usb_nrzi_tx: a full-speed (8 clk/bit) and a low-speed (1 clk/bit) instance.
module tb_usb_nrzi_tx;

  localparam int unsigned STUFF    = 6;
  localparam int unsigned SE0_BITS = 2;
  localparam int K_DATA  = 0;
  localparam int K_STUFF = 1;
  localparam int K_SE0   = 2;
  localparam int K_J     = 3;

  typedef struct {
    logic [1:0] sym;
    int         kind;
    bit         und;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst;

  logic fs_valid, fs_data, fs_last, fs_ready, fs_dp, fs_dm, fs_busy, fs_eop, fs_und;
  logic ls_valid, ls_data, ls_last, ls_ready, ls_dp, ls_dm, ls_busy, ls_eop, ls_und;

  int unsigned errors = 0;
  int unsigned checks = 0;

  bit   pkt_bits[$];
  exp_t exp_q[$];

  always #5 clk = ~clk;

  usb_nrzi_tx #(
    .CLKS_PER_BIT(8),
    .STUFF_LIMIT (6),
    .EOP_SE0_BITS(2),
    .LOW_SPEED   (1'b0)
  ) u_fs (
    .clk       (clk),
    .n_rst     (n_rst),
    .bit_valid (fs_valid),
    .bit_data  (fs_data),
    .bit_last  (fs_last),
    .bit_ready (fs_ready),
    .dplus_out (fs_dp),
    .dminus_out(fs_dm),
    .busy      (fs_busy),
    .eop_done  (fs_eop),
    .underrun  (fs_und)
  );

  usb_nrzi_tx #(
    .CLKS_PER_BIT(1),
    .STUFF_LIMIT (6),
    .EOP_SE0_BITS(2),
    .LOW_SPEED   (1'b1)
  ) u_ls (
    .clk       (clk),
    .n_rst     (n_rst),
    .bit_valid (ls_valid),
    .bit_data  (ls_data),
    .bit_last  (ls_last),
    .bit_ready (ls_ready),
    .dplus_out (ls_dp),
    .dminus_out(ls_dm),
    .busy      (ls_busy),
    .eop_done  (ls_eop),
    .underrun  (ls_und)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit ls, input logic v, input logic d, input logic l);
    if (ls) begin
      ls_valid = v; ls_data = d; ls_last = l;
    end else begin
      fs_valid = v; fs_data = d; fs_last = l;
    end
  endtask

  task automatic sample(input bit ls, output logic [1:0] line, output logic rdy,
                        output logic bsy, output logic eop, output logic und);
    if (ls) begin
      line = {ls_dp, ls_dm}; rdy = ls_ready; bsy = ls_busy; eop = ls_eop; und = ls_und;
    end else begin
      line = {fs_dp, fs_dm}; rdy = fs_ready; bsy = fs_busy; eop = fs_eop; und = fs_und;
    end
  endtask

  task automatic load_bits(input logic [31:0] v, input int unsigned n);
    pkt_bits.delete();
    for (int unsigned i = 0; i < n; i++) pkt_bits.push_back(v[i]);
  endtask

  // Reference: NRZI + stuffing + EOP, one entry per bit period
  task automatic build_expected(input logic [1:0] j, input logic [1:0] k, input bit abort_pkt);
    logic [1:0]  line;
    int unsigned ones;
    line = j;
    ones = 0;
    exp_q.delete();
    foreach (pkt_bits[i]) begin
      if (pkt_bits[i]) begin
        ones++;
      end else begin
        line = (line == j) ? k : j;
        ones = 0;
      end
      exp_q.push_back('{line, K_DATA, 1'b0});
      if (ones == STUFF) begin
        line = (line == j) ? k : j;
        ones = 0;
        exp_q.push_back('{line, K_STUFF, 1'b0});
      end
    end
    for (int unsigned i = 0; i < SE0_BITS; i++)
      exp_q.push_back('{2'b00, K_SE0, abort_pkt && (i == 0)});
    exp_q.push_back('{j, K_J, 1'b0});
  endtask

  task automatic run_packet(input string name, input bit ls, input int unsigned clks,
                            input bit abort_pkt);
    logic [1:0]  j, k, l;
    logic        r, b, e, u, cur_v, take;
    int unsigned idx, s, n;
    exp_t        cur;
    bit          nxt_take;
    n = pkt_bits.size();
    j = ls ? 2'b01 : 2'b10;
    k = ~j;
    build_expected(j, k, abort_pkt);
    @(negedge clk);
    cur_v = 1'b1;
    drive(ls, 1'b1, pkt_bits[0], !abort_pkt && (n == 1));
    sample(ls, l, r, b, e, u);
    check({name, " idle line"}, l, j);
    check({name, " idle ready"}, r, 1);
    check({name, " idle busy"}, b, 0);
    @(posedge clk); #1;
    idx = 1;
    if (idx < n) begin
      drive(ls, 1'b1, pkt_bits[idx], !abort_pkt && (idx == n - 1)); cur_v = 1'b1;
    end else begin
      drive(ls, 1'b0, 1'b0, 1'b0); cur_v = 1'b0;
    end
    s = 0;
    while (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      nxt_take = (exp_q.size() != 0) && ((exp_q[0].kind == K_DATA) || exp_q[0].und);
      for (int unsigned c = 0; c < clks; c++) begin
        @(negedge clk);
        sample(ls, l, r, b, e, u);
        check($sformatf("%s line s%0d c%0d", name, s, c), l, cur.sym);
        check($sformatf("%s busy s%0d c%0d", name, s, c), b, 1);
        check($sformatf("%s eop s%0d c%0d", name, s, c), e, 0);
        check($sformatf("%s underrun s%0d c%0d", name, s, c), u, cur.und && (c == 0));
        check($sformatf("%s ready s%0d c%0d", name, s, c), r, (c == clks - 1) && nxt_take);
        take = r && cur_v;
        @(posedge clk); #1;
        if (take) begin
          idx++;
          if (idx < n) begin
            drive(ls, 1'b1, pkt_bits[idx], !abort_pkt && (idx == n - 1)); cur_v = 1'b1;
          end else begin
            drive(ls, 1'b0, 1'b0, 1'b0); cur_v = 1'b0;
          end
        end
      end
      s++;
    end
    @(negedge clk);
    sample(ls, l, r, b, e, u);
    check({name, " done eop"}, e, 1);
    check({name, " done busy"}, b, 0);
    check({name, " done line"}, l, j);
    check({name, " done underrun"}, u, 0);
    check({name, " done ready"}, r, 1);
    check({name, " bits consumed"}, idx, n);
    @(negedge clk);
    sample(ls, l, r, b, e, u);
    check({name, " eop single pulse"}, e, 0);
  endtask

  initial begin
    logic [1:0] l;
    logic       r, b, e, u;
    n_rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset asserted mid-clock
    #3 n_rst = 1'b0;
    #1;
    check("reset fs line", {fs_dp, fs_dm}, 2'b10);
    check("reset fs busy", fs_busy, 0);
    check("reset fs eop", fs_eop, 0);
    check("reset fs underrun", fs_und, 0);
    check("reset ls line", {ls_dp, ls_dm}, 2'b01);
    check("reset ls busy", ls_busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) n_rst = 1'b1;
    @(negedge clk);
    check("post-reset fs ready", fs_ready, 1);
    check("post-reset ls ready", ls_ready, 1);

    // Eight zeros, last on the eighth
    load_bits(32'h0000_0000, 8);
    run_packet("sync", 1'b0, 8, 1'b0);

    // Seven ones then a zero: one stuffed bit after the sixth one
    load_bits(32'h0000_007F, 8);
    run_packet("stuff7", 1'b0, 8, 1'b0);

    // Six ones with last on the sixth: stuff precedes the EOP
    load_bits(32'h0000_003F, 6);
    run_packet("stufflast", 1'b0, 8, 1'b0);

    // Three bits then bit_valid drops: underrun abort
    load_bits(32'h0000_0005, 3);
    run_packet("underrun", 1'b0, 8, 1'b1);

    // Low-speed, one clock per bit, continuous stream with a stuff
    load_bits(32'h0000_017F, 10);
    run_packet("ls_stream", 1'b1, 1, 1'b0);

    // Reset in the middle of a packet
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (12) @(posedge clk);
    #2;
    check("midpkt busy before reset", fs_busy, 1);
    n_rst = 1'b0;
    #1;
    check("midpkt reset line", {fs_dp, fs_dm}, 2'b10);
    check("midpkt reset busy", fs_busy, 0);
    check("midpkt reset eop", fs_eop, 0);
    check("midpkt reset underrun", fs_und, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) n_rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      sample(1'b0, l, r, b, e, u);
      check("after midpkt line", l, 2'b10);
      check("after midpkt eop", e, 0);
      check("after midpkt underrun", u, 0);
      check("after midpkt ready", r, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
